// File: rtl/multibyte_add_seq_if.sv
// multibyte_add_seq_if: request/response and adder-stage signals of the
// sequential multi-byte adder, grouped for connection as a single port.
//   slave  : the multibyte_add_seq controller
//   master : whatever issues requests and hosts the 8-bit adder stage
interface multibyte_add_seq_if #(
  parameter int NBYTES = 4
);
  localparam int W = 8 * NBYTES;

  // request side
  logic         start;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         cin;
  logic         sub;

  // completion side
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout;
  logic         ovf;

  // 8-bit adder stage, combinational between adder_* outputs and inputs
  logic [7:0]   adder_a;
  logic [7:0]   adder_b;
  logic         adder_cin;
  logic [7:0]   adder_s;
  logic         adder_cout;

  modport slave (
    input  start, op_a, op_b, cin, sub,
    output busy, done, result, cout, ovf,
    output adder_a, adder_b, adder_cin,
    input  adder_s, adder_cout
  );

  modport master (
    output start, op_a, op_b, cin, sub,
    input  busy, done, result, cout, ovf,
    input  adder_a, adder_b, adder_cin,
    output adder_s, adder_cout
  );
endinterface

// File: rtl/multibyte_add_seq.sv
// multibyte_add_seq: drives an external 8-bit ripple adder one byte per cycle,
// chaining the carry between cycles, to form an NBYTES-wide sum.
// Optional feature macro: SUB_EN -- when defined, sub=1 computes A-B by
// inverting B bytes and forcing the initial carry to 1. When undefined the
// block always computes A+B+cin and the sub input is ignored.
//
// state  | meaning
// IDLE   | waiting for start
// RUN    | one operand byte per cycle through the adder stage
// DONE   | single-cycle completion pulse; start here chains straight into RUN
module multibyte_add_seq #(
  parameter int NBYTES = 4
) (
  input logic              clk,
  input logic              rst_n,
  multibyte_add_seq_if.slave bus
);
  localparam int         W      = 8 * NBYTES;
  localparam logic [2:0] K_LAST = 3'(NBYTES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t       r_state;
  state_t       w_state_nxt;
  logic         w_accept;
  logic         w_last;

  logic [W-1:0] r_a;
  logic [W-1:0] r_b;
  logic [W-1:0] r_asm;
  logic         r_carry;
  logic [2:0]   r_k;

  logic [W-1:0] r_result;
  logic         r_cout;
  logic         r_ovf;

  logic [7:0]   w_adder_a;
  logic [7:0]   w_adder_b;
  logic         w_adder_cin;
  logic [7:0]   w_b_byte;
  logic         w_carry_init;
  logic [W-1:0] w_asm_nxt;
  logic         w_ovf_nxt;

`ifdef SUB_EN
  logic         r_sub;

  // B byte is inverted for subtraction; the initial carry of 1 completes the negation
  assign w_b_byte     = r_b[7:0] ^ {8{r_sub}};
  assign w_carry_init = bus.sub ? 1'b1 : bus.cin;
`else
  logic         w_unused_sub;

  assign w_b_byte     = r_b[7:0];
  assign w_carry_init = bus.cin;
  assign w_unused_sub = bus.sub;
`endif

  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // next-state decode, operand acceptance and last-byte detection
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_accept    = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (r_k == K_LAST) begin
          w_last      = 1'b1;
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.start) begin
          w_accept    = 1'b1;
          w_state_nxt = S_RUN;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // adder stage inputs are only driven while a byte is in flight
  always_comb begin
    w_adder_a   = 8'h00;
    w_adder_b   = 8'h00;
    w_adder_cin = 1'b0;
    if (r_state == S_RUN) begin
      w_adder_a   = r_a[7:0];
      w_adder_b   = w_b_byte;
      w_adder_cin = r_carry;
    end
  end

  // each sum byte enters at the MSB end so byte 0 reaches the LSB after NBYTES shifts
  generate
    if (NBYTES == 1) begin : g_asm_one
      assign w_asm_nxt = bus.adder_s;
    end else begin : g_asm_multi
      assign w_asm_nxt = {bus.adder_s, r_asm[W-1:8]};
    end
  endgenerate

  // signed overflow from the sign bits of the most significant byte
  assign w_ovf_nxt = (w_adder_a[7] == w_adder_b[7]) && (bus.adder_s[7] != w_adder_a[7]);

  // operand shift registers, carry chain, byte counter and result assembly
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_asm   <= '0;
      r_carry <= 1'b0;
      r_k     <= 3'd0;
    end else if (w_accept) begin
      r_a     <= bus.op_a;
      r_b     <= bus.op_b;
      r_asm   <= '0;
      r_carry <= w_carry_init;
      r_k     <= 3'd0;
    end else if (r_state == S_RUN) begin
      r_a     <= r_a >> 8;
      r_b     <= r_b >> 8;
      r_asm   <= w_asm_nxt;
      r_carry <= bus.adder_cout;
      r_k     <= r_k + 3'd1;
    end
  end

`ifdef SUB_EN
  // subtract mode is fixed for the whole operation
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sub <= 1'b0;
    end else if (w_accept) begin
      r_sub <= bus.sub;
    end
  end
`endif

  // completion results, held until the next completion or reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_result <= '0;
      r_cout   <= 1'b0;
      r_ovf    <= 1'b0;
    end else if (w_last) begin
      r_result <= w_asm_nxt;
      r_cout   <= bus.adder_cout;
      r_ovf    <= w_ovf_nxt;
    end
  end

  assign bus.busy      = (r_state == S_RUN);
  assign bus.done      = (r_state == S_DONE);
  assign bus.result    = r_result;
  assign bus.cout      = r_cout;
  assign bus.ovf       = r_ovf;
  assign bus.adder_a   = w_adder_a;
  assign bus.adder_b   = w_adder_b;
  assign bus.adder_cin = w_adder_cin;

endmodule

// File: tb/tb_multibyte_add_seq.sv
// tb_multibyte_add_seq: directed scenarios for multibyte_add_seq with NBYTES=4.
// The bench hosts the 8-bit adder stage as a combinational model.
module tb_multibyte_add_seq;
  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  multibyte_add_seq_if #(.NBYTES(4)) bus ();

  multibyte_add_seq #(.NBYTES(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  assign {bus.adder_cout, bus.adder_s} =
    {1'b0, bus.adder_a} + {1'b0, bus.adder_b} + {8'h00, bus.adder_cin};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // present a request for one cycle; returns just after the accepting edge (cycle 1)
  task automatic start_op(input logic [31:0] a, input logic [31:0] b,
                          input logic ci, input logic sb);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op_a  = a;
    bus.op_b  = b;
    bus.cin   = ci;
    bus.sub   = sb;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // counts sampled cycles until done (bounded); busy_cyc counts busy samples before done
  task automatic wait_done(output int cyc, output int busy_cyc);
    bit seen;
    seen     = 1'b0;
    cyc      = 0;
    busy_cyc = 0;
    while (!seen && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (bus.done === 1'b1) seen = 1'b1;
      else if (bus.busy === 1'b1) busy_cyc++;
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.op_a  = '0;
    bus.op_b  = '0;
    bus.cin   = 1'b0;
    bus.sub   = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    checks++; if (bus.result !== 32'h0) begin errors++; $display("FAIL reset_result got=%h exp=00000000", bus.result); end
    checks++; if ({bus.cout, bus.ovf} !== 2'b00) begin errors++; $display("FAIL reset_cout_ovf got=%b exp=00", {bus.cout, bus.ovf}); end
    checks++; if ({bus.adder_a, bus.adder_b, bus.adder_cin} !== 17'h0) begin errors++; $display("FAIL reset_adder_ports got=%h exp=0", {bus.adder_a, bus.adder_b, bus.adder_cin}); end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_carry_chain();
    int cyc, bc;
    start_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0);
    @(negedge clk);
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL chain_busy_c1 got=%b exp=1", bus.busy); end
    checks++; if ({bus.adder_a, bus.adder_b, bus.adder_cin} !== {8'hFF, 8'h01, 1'b0}) begin
      errors++; $display("FAIL chain_adder_c1 got=%h/%h/%b exp=ff/01/0", bus.adder_a, bus.adder_b, bus.adder_cin); end
    wait_done(cyc, bc);
    checks++; if (cyc !== 4) begin errors++; $display("FAIL chain_done_cycle got=%0d exp=5", cyc + 1); end
    checks++; if (bc !== 3) begin errors++; $display("FAIL chain_busy_cycles got=%0d exp=4", bc + 1); end
    checks++; if (bus.result !== 32'h0000_0100) begin errors++; $display("FAIL chain_result got=%h exp=00000100", bus.result); end
    checks++; if ({bus.cout, bus.ovf} !== 2'b00) begin errors++; $display("FAIL chain_cout_ovf got=%b exp=00", {bus.cout, bus.ovf}); end
    checks++; if ({bus.busy, bus.adder_a, bus.adder_cin} !== 10'h0) begin errors++; $display("FAIL chain_done_idle_ports got=%h exp=0", {bus.busy, bus.adder_a, bus.adder_cin}); end
    @(negedge clk);
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL chain_done_pulse_width got=%b exp=0", bus.done); end
    checks++; if (bus.result !== 32'h0000_0100) begin errors++; $display("FAIL chain_result_held got=%h exp=00000100", bus.result); end
  endtask

  task automatic test_wrap();
    int cyc, bc;
    start_op(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0);
    wait_done(cyc, bc);
    checks++; if (cyc !== 5) begin errors++; $display("FAIL wrap_done_cycle got=%0d exp=5", cyc); end
    checks++; if (bus.result !== 32'h0) begin errors++; $display("FAIL wrap_result got=%h exp=00000000", bus.result); end
    checks++; if ({bus.cout, bus.ovf} !== 2'b10) begin errors++; $display("FAIL wrap_cout_ovf got=%b exp=10", {bus.cout, bus.ovf}); end
  endtask

  task automatic test_overflow();
    int cyc, bc;
    start_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    wait_done(cyc, bc);
    checks++; if (cyc !== 5) begin errors++; $display("FAIL ovf_done_cycle got=%0d exp=5", cyc); end
    checks++; if (bus.result !== 32'h8000_0000) begin errors++; $display("FAIL ovf_result got=%h exp=80000000", bus.result); end
    checks++; if ({bus.cout, bus.ovf} !== 2'b01) begin errors++; $display("FAIL ovf_cout_ovf got=%b exp=01", {bus.cout, bus.ovf}); end
  endtask

  task automatic test_sub();
    int cyc, bc;
    start_op(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1);
    wait_done(cyc, bc);
    checks++; if (cyc !== 5) begin errors++; $display("FAIL sub1_done_cycle got=%0d exp=5", cyc); end
`ifdef SUB_EN
    checks++; if (bus.result !== 32'hFFFF_FFFE) begin errors++; $display("FAIL sub1_result got=%h exp=fffffffe", bus.result); end
    checks++; if ({bus.cout, bus.ovf} !== 2'b00) begin errors++; $display("FAIL sub1_cout_ovf got=%b exp=00", {bus.cout, bus.ovf}); end
    start_op(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1);
    wait_done(cyc, bc);
    checks++; if (bus.result !== 32'h7FFF_FFFF) begin errors++; $display("FAIL sub2_result got=%h exp=7fffffff", bus.result); end
    checks++; if ({bus.cout, bus.ovf} !== 2'b11) begin errors++; $display("FAIL sub2_cout_ovf got=%b exp=11", {bus.cout, bus.ovf}); end
`else
    checks++; if (bus.result !== 32'h0000_000C) begin errors++; $display("FAIL sub_ignored_result got=%h exp=0000000c", bus.result); end
    checks++; if ({bus.cout, bus.ovf} !== 2'b00) begin errors++; $display("FAIL sub_ignored_cout_ovf got=%b exp=00", {bus.cout, bus.ovf}); end
`endif
  endtask

  task automatic test_start_ignored();
    int cyc, bc;
    start_op(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
    @(negedge clk);                  // cycle 1
    @(negedge clk);                  // cycle 2
    bus.start = 1'b1;
    bus.op_a  = 32'hFFFF_FFFF;
    bus.op_b  = 32'hFFFF_FFFF;
    @(negedge clk);                  // cycle 3
    bus.start = 1'b0;
    wait_done(cyc, bc);
    checks++; if (cyc !== 2) begin errors++; $display("FAIL ign_done_cycle got=%0d exp=5", cyc + 3); end
    checks++; if (bus.result !== 32'h2345_6789) begin errors++; $display("FAIL ign_result got=%h exp=23456789", bus.result); end
    @(negedge clk);
    checks++; if ({bus.busy, bus.done} !== 2'b00) begin errors++; $display("FAIL ign_no_requeue got=%b exp=00", {bus.busy, bus.done}); end
  endtask

  task automatic test_back_to_back();
    int cyc, bc;
    @(negedge clk);
    bus.start = 1'b1;
    bus.op_a  = 32'h0000_0001;
    bus.op_b  = 32'h0000_0002;
    bus.cin   = 1'b0;
    bus.sub   = 1'b0;
    @(posedge clk);
    #1;
    bus.op_a  = 32'h0000_0010;
    bus.op_b  = 32'h0000_0020;
    wait_done(cyc, bc);
    checks++; if (cyc !== 5) begin errors++; $display("FAIL b2b_first_done_cycle got=%0d exp=5", cyc); end
    checks++; if (bus.result !== 32'h0000_0003) begin errors++; $display("FAIL b2b_first_result got=%h exp=00000003", bus.result); end
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    @(negedge clk);
    checks++; if ({bus.busy, bus.done} !== 2'b10) begin errors++; $display("FAIL b2b_no_idle_gap got=%b exp=10", {bus.busy, bus.done}); end
    wait_done(cyc, bc);
    checks++; if (cyc !== 4) begin errors++; $display("FAIL b2b_second_done_cycle got=%0d exp=5", cyc + 1); end
    checks++; if (bus.result !== 32'h0000_0030) begin errors++; $display("FAIL b2b_second_result got=%h exp=00000030", bus.result); end
  endtask

  task automatic test_reset_mid_run();
    int dones;
    start_op(32'h0101_0101, 32'h0202_0202, 1'b0, 1'b0);
    @(posedge clk);                  // start of cycle 2
    @(posedge clk);                  // start of cycle 3
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rstrun_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.result !== 32'h0) begin errors++; $display("FAIL rstrun_result got=%h exp=00000000", bus.result); end
    checks++; if (bus.adder_a !== 8'h00) begin errors++; $display("FAIL rstrun_adder_a got=%h exp=00", bus.adder_a); end
    dones = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) dones++;
    end
    checks++; if (dones !== 0) begin errors++; $display("FAIL rstrun_no_done got=%0d exp=0", dones); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_carry_chain();
    test_wrap();
    test_overflow();
    test_sub();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/multibyte_add_seq.md
# multibyte_add_seq

Sequential multi-byte adder controller that sits around the team's 8-bit combinational ripple-carry adder stage. It feeds that stage one operand byte per cycle and consumes its 8-bit sum and carry-out. It chains the carry between cycles and assembles a full-width result. This lets one 8-bit adder serve 16/32/64-bit additions, trading latency for area.

## Interface
Parameters:
- NBYTES, 4, operand width in bytes; legal range 1..8; total width W = 8*NBYTES.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; synchronous, active-low.
- start  in  1  request; sampled only in IDLE or DONE.
- op_a  in  W  operand A; captured when start is accepted.
- op_b  in  W  operand B; captured when start is accepted.
- cin  in  1  carry-in for byte 0; captured with the operands.
- sub  in  1  subtract request; captured with the operands; ignored unless SUB_EN is defined.
- busy  out  1  high while the block is in RUN.
- done  out  1  one-cycle pulse; high while the block is in DONE.
- result  out  W  final sum; held until the next completion or reset.
- cout  out  1  final carry-out of the MSB byte.
- ovf  out  1  two's-complement signed overflow of the full-width operation.
- adder_a  out  8  byte of A driven to the adder stage.
- adder_b  out  8  effective byte of B driven to the adder stage.
- adder_cin  out  1  carry driven to the adder stage.
- adder_s  in  8  sum returned by the adder stage; combinational within the same cycle.
- adder_cout  in  1  carry-out returned by the adder stage.

## Operation
- FSM states: IDLE, RUN, DONE. Reset state: IDLE.
- IDLE, start=1 -> RUN. On acceptance, latch:
  - op_a and op_b into shift registers;
  - the carry register: cin normally, or 1 when subtracting;
  - the subtract mode.
  - Byte counter k=0.
- RUN, each cycle:
  - adder_a = A shift-reg low byte.
  - adder_b = B low byte, inverted when subtracting.
  - adder_cin = carry register.
  - At the clock edge: adder_s shifts into the result assembly register from the MSB end; carry register <= adder_cout; the A/B registers shift right 8 bits; k increments.
- RUN -> DONE after the edge at which k=NBYTES-1 is processed. On that edge, update:
  - result = assembled value;
  - cout = adder_cout;
  - ovf = (a_msb == beff_msb) && (s_msb != a_msb), using bit 7 of the final byte.
- DONE lasts exactly one cycle. start=1 in DONE -> RUN directly (back-to-back accepted). Otherwise DONE -> IDLE.
- start while in RUN is ignored; no queuing.
- Outside RUN: adder_a=0, adder_b=0, adder_cin=0.
- Operand inputs are don't-care except in the cycle start is accepted.
- Arithmetic is modulo 2^W.
- cout semantics:
  - add: carry out of bit W-1;
  - subtract: 1 = no borrow (A >= B unsigned).
- Reset (rst_n=0 at an edge), in any state including mid-RUN:
  - state -> IDLE; counter, shift registers and carry register cleared.
  - Outputs: busy=0, done=0, result=0, cout=0, ovf=0.
  - The partial result is discarded.

## Timing
- Cycle 0: start high while in IDLE or DONE; accepted at the edge.
- Cycles 1..NBYTES: busy=1; byte k=c-1 presented on the adder ports.
- Cycle NBYTES+1: done=1, busy=0; result, cout and ovf are valid and remain stable afterwards.
- Latency from start to done: NBYTES+1 cycles. Back-to-back throughput: one operation per NBYTES+1 cycles.
- The adder path (adder_a/b/cin -> adder_s/cout -> registers) is single-cycle combinational. No registering happens on the adder ports.
- Reset values: busy=0, done=0, result=0, cout=0, ovf=0, adder_a=0, adder_b=0, adder_cin=0.

## Configuration
- SUB_EN defined:
  - the sub port is honoured;
  - sub=1 computes A-B: B bytes are inverted and the initial carry is forced to 1, with cin ignored;
  - ovf uses the inverted B MSB.
- SUB_EN undefined: the sub port is ignored, the inversion logic is absent, and the block always computes A+B+cin.

## Test plan
NBYTES=4 for all scenarios.
- Byte-carry chain: A=0x000000FF, B=0x00000001, cin=0 -> result=0x00000100, cout=0, ovf=0; done exactly in cycle 5 and busy high in cycles 1-4.
- Full wrap: A=0xFFFFFFFF, B=0x00000000, cin=1 -> result=0x00000000, cout=1, ovf=0.
- Signed overflow: A=0x7FFFFFFF, B=0x00000001, cin=0 -> result=0x80000000, cout=0, ovf=1.
- SUB_EN defined, sub=1:
  - A=5, B=7 -> result=0xFFFFFFFE, cout=0, ovf=0;
  - A=0x80000000, B=1 -> result=0x7FFFFFFF, cout=1, ovf=1.
- Control: start pulsed in cycle 2 of a run -> ignored, first result unchanged. start held through DONE -> second operation begins with no IDLE gap. rst_n=0 in cycle 3 -> next cycle has busy=0, result=0, and no done pulse ever appears.
